// File: rtl/seq_detector_param.sv
// Serial pattern detector: compares the last PAT_W sampled bits against a loadable
// pattern and emits a registered one-cycle pulse per match, with a saturating match count.
module seq_detector_param #(
  parameter int             PAT_W     = 4,
  parameter logic [PAT_W-1:0] PAT_RESET = 4'b1101,
  parameter int             CNT_W     = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             w,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             clr_cnt,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int FW = $clog2(PAT_W);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

  typedef enum logic {S_FILL, S_ARMED} state_e;

  state_e           state_q, state_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, sat_q, sat_d;
  logic [PAT_W-1:0] shifted;
  logic             match;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_FILL;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= PAT_RESET;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      out_q   <= match;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    shifted = {hist_q, w};
    // Mealy match on the incoming bit; a pattern load wins over any sampled bit
    match   = en & ~pat_load & (state_q == S_ARMED) & (shifted == pat_q);

    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = shifted[PAT_W-2:0];
      fill_d = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
      if (match && !overlap) fill_d = '0;
    end

    state_d = (fill_d == FILL_MAX) ? S_ARMED : S_FILL;

    if (clr_cnt)                     cnt_d = '0;
    else if (match && cnt_q != '1)   cnt_d = cnt_q + 1'b1;
    sat_d = (cnt_d == '1);
  end

  assign out       = out_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param (PAT_W=4, CNT_W=3): a bit-history reference
// model queues expected outputs per driven cycle; they are popped after each clock edge.
module tb_seq_detector_param;

  localparam int PAT_W = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             clr, en, w, overlap, pat_load, clr_cnt;
  logic [PAT_W-1:0] pat_in;
  logic             out;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  seq_detector_param #(.PAT_W(PAT_W), .PAT_RESET(4'b1101), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr), .en(en), .w(w), .overlap(overlap), .pat_load(pat_load),
    .pat_in(pat_in), .clr_cnt(clr_cnt), .out(out), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       out;
    logic [2:0] cnt;
    logic       sat;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0, n_mis = 0, pulses = 0;
  bit         mb[$];
  logic [3:0] mpat;
  int         mcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mb.delete();
    mpat = 4'b1101;
    mcnt = 0;
  endtask

  // Reference: keep the bits received since the last restart, match on the newest four.
  task automatic model_step(input bit e, input bit b, input bit ov, input bit pl,
                            input logic [3:0] pin, input bit cc);
    exp_t x;
    bit   m = 1'b0;
    if (pl) begin
      mpat = pin;
      mb.delete();
    end else if (e) begin
      mb.push_back(b);
      if (mb.size() > 4) void'(mb.pop_front());
      if (mb.size() == 4 && {mb[0], mb[1], mb[2], mb[3]} == mpat) begin
        m = 1'b1;
        if (!ov) mb.delete();
      end
    end
    if (cc) mcnt = 0;
    else if (m && mcnt < 7) mcnt++;
    x.out = m;
    x.cnt = 3'(mcnt);
    x.sat = (mcnt == 7);
    sb.push_back(x);
  endtask

  task automatic step(input string tag, input bit e, input bit b,
                      input bit pl = 1'b0, input logic [3:0] pin = 4'b0, input bit cc = 1'b0);
    exp_t x;
    en = e; w = b; pat_load = pl; pat_in = pin; clr_cnt = cc;
    model_step(e, b, overlap, pl, pin, cc);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      chk({tag, "_out"}, 32'(out), 32'(x.out));
      chk({tag, "_cnt"}, 32'(match_cnt), 32'(x.cnt));
      chk({tag, "_sat"}, 32'(cnt_sat), 32'(x.sat));
    end
    if (out) pulses++;
    @(negedge clk);
    pat_load = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic stream(input string tag, input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(tag, 1'b1, bits[i]);
  endtask

  task automatic load(input logic [3:0] p, input bit cc);
    step("load", 1'b0, 1'b0, 1'b1, p, cc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b0; en = 1'b0; w = 1'b0; overlap = 1'b1; pat_load = 1'b0;
    pat_in = '0; clr_cnt = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_sat", 32'(cnt_sat), 32'd0);
    clr = 1'b1;

    // 1) async reset mid-pattern, then default pattern 1101
    stream("t1a", 32'b110, 3);
    clr = 1'b0;
    #1;
    chk("t1_midrst_out", 32'(out), 32'd0);
    chk("t1_midrst_cnt", 32'(match_cnt), 32'd0);
    chk("t1_midrst_sat", 32'(cnt_sat), 32'd0);
    model_reset();
    @(negedge clk);
    clr = 1'b1;
    pulses = 0;
    stream("t1b", 32'b110, 3);
    step("t1_last", 1'b1, 1'b1);
    chk("t1_pulse", 32'(pulses), 32'd1);

    // 2) overlapping matches
    load(4'b1011, 1'b1);
    overlap = 1'b1; pulses = 0;
    stream("t2", 32'b1011011, 7);
    chk("t2_pulses", 32'(pulses), 32'd2);
    chk("t2_cnt", 32'(match_cnt), 32'd2);

    // 3) non-overlapping
    load(4'b1011, 1'b1);
    overlap = 1'b0; pulses = 0;
    stream("t3a", 32'b1011011, 7);
    chk("t3_pulses", 32'(pulses), 32'd1);
    chk("t3_cnt1", 32'(match_cnt), 32'd1);
    stream("t3b", 32'b1011, 4);
    chk("t3_cnt2", 32'(match_cnt), 32'd2);

    // 4) en gaps inside a pattern
    load(4'b1011, 1'b1);
    overlap = 1'b1; pulses = 0;
    stream("t4a", 32'b10, 2);
    for (int i = 0; i < 3; i++) step("t4gap", 1'b0, i[0]);
    stream("t4b", 32'b11, 2);
    chk("t4_pulses", 32'(pulses), 32'd1);

    // 5) pattern load mid-stream, sampled bit ignored
    load(4'b1011, 1'b1);
    pulses = 0;
    stream("t5a", 32'b101, 3);
    step("t5_load", 1'b1, 1'b1, 1'b1, 4'b0110);
    chk("t5_load_out", 32'(out), 32'd0);
    stream("t5b", 32'b10110, 5);
    chk("t5_pulses", 32'(pulses), 32'd1);

    // 6) saturation, then clear colliding with a match
    load(4'b1011, 1'b1);
    overlap = 1'b1;
    stream("t6a", 32'b1011, 4);
    for (int i = 0; i < 8; i++) stream("t6b", 32'b011, 3);
    chk("t6_cnt_sat", 32'(match_cnt), 32'd7);
    chk("t6_sat", 32'(cnt_sat), 32'd1);
    stream("t6c", 32'b01, 2);
    step("t6_clr", 1'b1, 1'b1, 1'b0, 4'b0, 1'b1);
    chk("t6_clr_out", 32'(out), 32'd1);
    chk("t6_clr_cnt", 32'(match_cnt), 32'd0);
    chk("t6_clr_sat", 32'(cnt_sat), 32'd0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      overlap = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0)
        step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
             4'($urandom_range(0, 15)), 1'b0);
      else
        step("rnd", ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0, 4'b0,
             ($urandom_range(0, 49) == 0));
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
